// File: rtl/hash_sequencer.sv
// hash_sequencer: round-robin job sequencer for the shared Keccak-f[1600] core.
// Ports: req_i/nblk*_i request side, grant_o owner, in_* absorb lane handshake,
//   st_clr_o/lane_xor_o/lane_idx_o/perm_en_o/round_idx_o core control,
//   out_* squeeze lane handshake, done_o end-of-job pulse; ovr_rst1 async high.
module hash_sequencer #(
   parameter int unsigned ROUNDS     = 24,
   parameter int unsigned RATE_LANES = 17,
   parameter int unsigned OUT_LANES  = 4,
   parameter int unsigned NBLK_W     = 8
) (
   input  logic              clk,
   input  logic              ovr_rst1,
   input  logic [1:0]        req_i,
   input  logic [NBLK_W-1:0] nblk0_i,
   input  logic [NBLK_W-1:0] nblk1_i,
   output logic [1:0]        grant_o,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              st_clr_o,
   output logic              lane_xor_o,
   output logic [4:0]        lane_idx_o,
   output logic              perm_en_o,
   output logic [4:0]        round_idx_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ABSORB,
      S_PERMUTE,
      S_SQUEEZE,
      S_DONE
   } state_e;

   localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);
   localparam logic [4:0] LAST_OUT  = 5'(OUT_LANES - 1);
   localparam logic [4:0] LAST_RND  = 5'(ROUNDS - 1);

   state_e            state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic [4:0]        lane_q, lane_d;
   logic [4:0]        round_q, round_d;
   logic [NBLK_W-1:0] blk_q, blk_d;
   logic [NBLK_W-1:0] nblk_q, nblk_d;
   logic              last_q, last_d;

   logic              st_clr_q, in_ready_q, perm_en_q;
   logic              out_valid_q, done_q;

   logic              win;
   logic [NBLK_W-1:0] nblk_sel;
   logic [NBLK_W-1:0] blk_inc;

   // Contention goes to the requester that did not own the previous job.
   assign win      = (req_i == 2'b11) ? ~last_q : req_i[1];
   assign nblk_sel = win ? nblk1_i : nblk0_i;
   assign blk_inc  = blk_q + NBLK_W'(1);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      lane_d  = lane_q;
      round_d = round_q;
      blk_d   = blk_q;
      nblk_d  = nblk_q;
      last_d  = last_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_i != 2'b00) begin
               grant_d = win ? 2'b10 : 2'b01;
               // A zero block count still runs one block.
               nblk_d  = (nblk_sel == '0) ? NBLK_W'(1) : nblk_sel;
               blk_d   = '0;
               lane_d  = '0;
               round_d = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            lane_d  = '0;
            state_d = S_ABSORB;
         end
         S_ABSORB: begin
            if (in_valid_i) begin
               if (lane_q == LAST_LANE) begin
                  round_d = '0;
                  state_d = S_PERMUTE;
               end else begin
                  lane_d = lane_q + 5'd1;
               end
            end
         end
         S_PERMUTE: begin
            if (round_q == LAST_RND) begin
               blk_d   = blk_inc;
               lane_d  = '0;
               state_d = (blk_inc == nblk_q) ? S_SQUEEZE : S_ABSORB;
            end else begin
               round_d = round_q + 5'd1;
            end
         end
         S_SQUEEZE: begin
            if (out_ready_i) begin
               if (lane_q == LAST_OUT) begin
                  state_d = S_DONE;
               end else begin
                  lane_d = lane_q + 5'd1;
               end
            end
         end
         S_DONE: begin
            last_d  = grant_q[1];
            grant_d = 2'b00;
            lane_d  = '0;
            round_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            grant_d = 2'b00;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge ovr_rst1) begin
      if (ovr_rst1) begin
         state_q     <= S_IDLE;
         grant_q     <= 2'b00;
         lane_q      <= '0;
         round_q     <= '0;
         blk_q       <= '0;
         nblk_q      <= '0;
         last_q      <= 1'b1;
         st_clr_q    <= 1'b0;
         in_ready_q  <= 1'b0;
         perm_en_q   <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lane_q      <= lane_d;
         round_q     <= round_d;
         blk_q       <= blk_d;
         nblk_q      <= nblk_d;
         last_q      <= last_d;
         st_clr_q    <= (state_d == S_CLEAR);
         in_ready_q  <= (state_d == S_ABSORB);
         perm_en_q   <= (state_d == S_PERMUTE);
         out_valid_q <= (state_d == S_SQUEEZE);
         done_q      <= (state_d == S_DONE);
      end
   end

   assign grant_o     = grant_q;
   assign in_ready_o  = in_ready_q;
   assign st_clr_o    = st_clr_q;
   assign lane_xor_o  = in_valid_i & in_ready_q;
   assign lane_idx_o  = lane_q;
   assign perm_en_o   = perm_en_q;
   assign round_idx_o = round_q;
   assign out_valid_o = out_valid_q;
   assign done_o      = done_q;

endmodule
